// File: rtl/bitonic_sort_ctrl.sv
// Block bitonic sorter: loads DEPTH words, sorts them in place with one shared
// compare-swap per cycle, then streams the sorted block out over valid/ready.
module bitonic_sort_ctrl #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             sort_desc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
);
   localparam int L  = $clog2(DEPTH);
   localparam int CW = L + 1;
   localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LAST_PAIR = CW'(DEPTH / 2 - 1);
   localparam logic [CW-1:0] FULL_K    = CW'(DEPTH);
   localparam logic [CW-1:0] ONE       = CW'(1);

   typedef enum logic [1:0] {S_LOAD, S_SORT, S_DRAIN} state_t;

   state_t                        state_q, state_d;
   logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
   logic [CW-1:0]                 idx_q, idx_d, k_q, k_d, j_q, j_d, p_q, p_d;
   logic                          desc_q, desc_d;
   logic                          in_ready_q, in_ready_d;
   logic                          out_valid_q, out_valid_d;
   logic                          out_last_q, out_last_d;
   logic                          busy_q, busy_d;

   logic [CW-1:0]                 a;
   logic [L-1:0]                  b;
   logic [WIDTH-1:0]              va, vb, lo, hi;
   logic                          up;

   always_comb begin
      // a = p with a zero spliced in at bit log2(j); b is its partner
      a  = ((p_q & ~(j_q - ONE)) << 1) | (p_q & (j_q - ONE));
      b  = a[L-1:0] | j_q[L-1:0];
      va = mem_q[a[L-1:0]];
      vb = mem_q[b];
      lo = (va <= vb) ? va : vb;
      hi = (va <= vb) ? vb : va;
      // a < DEPTH, so the k==DEPTH bit test is always zero
      up = ((a & k_q) == '0) ^ desc_q;

      state_d     = state_q;
      mem_d       = mem_q;
      idx_d       = idx_q;
      k_d         = k_q;
      j_d         = j_q;
      p_d         = p_q;
      desc_d      = desc_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;

      case (state_q)
         S_LOAD: begin
            if (in_valid && in_ready_q) begin
               mem_d[idx_q[L-1:0]] = in_data;
               if (idx_q == '0) desc_d = sort_desc;
               if (idx_q == LAST_IDX) begin
                  state_d    = S_SORT;
                  idx_d      = '0;
                  k_d        = CW'(2);
                  j_d        = ONE;
                  p_d        = '0;
                  in_ready_d = 1'b0;
                  busy_d     = 1'b1;
               end else begin
                  idx_d = idx_q + ONE;
               end
            end
         end
         S_SORT: begin
            if (up) begin
               mem_d[a[L-1:0]] = lo;
               mem_d[b]        = hi;
            end else begin
               mem_d[a[L-1:0]] = hi;
               mem_d[b]        = lo;
            end
            if (p_q == LAST_PAIR) begin
               p_d = '0;
               if (j_q == ONE) begin
                  if (k_q == FULL_K) begin
                     state_d     = S_DRAIN;
                     idx_d       = '0;
                     out_valid_d = 1'b1;
                     out_last_d  = 1'b0;
                  end else begin
                     k_d = k_q << 1;
                     j_d = k_q;
                  end
               end else begin
                  j_d = j_q >> 1;
               end
            end else begin
               p_d = p_q + ONE;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (out_last_q) begin
                  state_d     = S_LOAD;
                  idx_d       = '0;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  busy_d      = 1'b0;
                  in_ready_d  = 1'b1;
               end else begin
                  idx_d      = idx_q + ONE;
                  out_last_d = ((idx_q + ONE) == LAST_IDX);
               end
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_LOAD;
         idx_q       <= '0;
         k_q         <= '0;
         j_q         <= '0;
         p_q         <= '0;
         desc_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         k_q         <= k_d;
         j_q         <= j_d;
         p_q         <= p_d;
         desc_q      <= desc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

   // storage is deliberately left out of reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign out_data  = mem_q[idx_q[L-1:0]];
endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Self-checking bench for bitonic_sort_ctrl: table vectors, corner sequences,
// random blocks against a queue-sort model, plus DEPTH=2 and DEPTH=16 instances.
module tb_bitonic_sort_ctrl;
   localparam int W = 32;
   localparam int D = 8;
   typedef logic [D-1:0][W-1:0] blk_t;
   typedef struct packed {
      blk_t din;
      logic desc;
      blk_t dexp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         in_valid, in_ready, sort_desc, out_valid, out_ready, out_last, busy;
   logic [W-1:0] in_data, out_data;

   bitonic_sort_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .sort_desc(sort_desc), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy));

   logic       in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2;
   logic [7:0] in_data2, out_data2;
   bitonic_sort_ctrl #(.WIDTH(8), .DEPTH(2)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .sort_desc(1'b0), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_data(out_data2), .out_last(out_last2), .busy(busy2));

   logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16, busy16;
   logic [15:0] in_data16, out_data16;
   bitonic_sort_ctrl #(.WIDTH(16), .DEPTH(16)) u_d16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
      .sort_desc(1'b1), .out_valid(out_valid16), .out_ready(out_ready16),
      .out_data(out_data16), .out_last(out_last16), .busy(busy16));

   int nvec = 0;
   int nerr = 0;
   vec_t tbl [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic blk_t pk(input logic [W-1:0] v0, v1, v2, v3, v4, v5, v6, v7);
      return {v7, v6, v5, v4, v3, v2, v1, v0};
   endfunction

   // reference: plain software sort of the block
   function automatic blk_t model(input blk_t d, input logic desc);
      logic [W-1:0] q[$];
      blk_t r;
      for (int i = 0; i < D; i++) q.push_back(d[i]);
      if (desc) q.rsort(); else q.sort();
      for (int i = 0; i < D; i++) r[i] = q[i];
      return r;
   endfunction

   task automatic load_blk(input blk_t d, input logic desc, input bit gaps, input bit flip);
      for (int i = 0; i < D; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         in_valid  = 1'b1;
         in_data   = d[i];
         sort_desc = (flip && i > 0) ? ~desc : desc;
         #1 chk("in_ready_load", in_ready, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("in_ready_sort", in_ready, 0);
      chk("busy_sort", busy, 1);
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: random with a 5-cycle stall at word 3
   task automatic drain_blk(input blk_t e, input int mode);
      int n = 0;
      int stall = 0;
      int cyc = 0;
      while (n < D && cyc < 400) begin
         if (out_valid !== 1'b1) begin
            chk("drain_valid", out_valid, 1);
            break;
         end
         if (mode == 0) out_ready = 1'b1;
         else if (mode == 2 && n == 3 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
         end else out_ready = ($urandom_range(0, 3) != 0);
         chk("out_data", out_data, e[n]);
         chk("out_last", out_last, n == D - 1);
         chk("in_ready_drain", in_ready, 0);
         @(negedge clk);
         if (out_ready) n++;
         cyc++;
      end
      out_ready = 1'b0;
      chk("drain_count", n, D);
      chk("in_ready_after", in_ready, 1);
      chk("out_valid_after", out_valid, 0);
      chk("busy_after", busy, 0);
   endtask

   task automatic run_blk(input blk_t din, input logic desc, input blk_t dexp,
                          input bit gaps, input bit flip, input int mode);
      int lat;
      load_blk(din, desc, gaps, flip);
      wait_out(lat);
      chk("latency", lat, 25);
      drain_blk(dexp, mode);
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_in_ready"}, in_ready, 1);
      chk({nm, "_out_valid"}, out_valid, 0);
      chk({nm, "_busy"}, busy, 0);
   endtask

   task automatic run_d2();
      logic [7:0] v [2];
      int n = 0;
      for (int i = 0; i < 2; i++) begin
         v[i]      = 8'($urandom);
         in_valid2 = 1'b1;
         in_data2  = v[i];
         @(negedge clk);
      end
      in_valid2 = 1'b0;
      while (out_valid2 !== 1'b1 && n < 200) begin
         if (busy2) n++;
         @(negedge clk);
      end
      chk("sort_len_d2", n, 1);
      out_ready2 = 1'b1;
      chk("d2_w0", out_data2, (v[0] < v[1]) ? v[0] : v[1]);
      chk("d2_last0", out_last2, 0);
      @(negedge clk);
      chk("d2_w1", out_data2, (v[0] < v[1]) ? v[1] : v[0]);
      chk("d2_last1", out_last2, 1);
      @(negedge clk);
      out_ready2 = 1'b0;
      chk("d2_in_ready", in_ready2, 1);
   endtask

   task automatic run_d16();
      logic [15:0] q[$];
      int n = 0;
      for (int i = 0; i < 16; i++) begin
         q.push_back(16'($urandom_range(0, 40)));
         in_valid16 = 1'b1;
         in_data16  = q[i];
         @(negedge clk);
      end
      in_valid16 = 1'b0;
      q.rsort();
      while (out_valid16 !== 1'b1 && n < 300) begin
         if (busy16) n++;
         @(negedge clk);
      end
      chk("sort_len_d16", n, 80);
      out_ready16 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("d16_data", out_data16, q[i]);
         chk("d16_last", out_last16, i == 15);
         @(negedge clk);
      end
      out_ready16 = 1'b0;
      chk("d16_in_ready", in_ready16, 1);
   endtask

   initial begin
      blk_t d;
      logic desc;
      int lat;

      tbl[0] = '{pk(5, 3, 7, 1, 8, 2, 6, 4), 1'b0, pk(1, 2, 3, 4, 5, 6, 7, 8)};
      tbl[1] = '{pk(0, 32'hFFFFFFFF, 9, 9, 0, 1, 32'hFFFFFFFF, 2), 1'b1,
                 pk(32'hFFFFFFFF, 32'hFFFFFFFF, 9, 9, 2, 1, 0, 0)};
      tbl[2] = '{pk(7, 7, 7, 7, 7, 7, 7, 7), 1'b0, pk(7, 7, 7, 7, 7, 7, 7, 7)};
      tbl[3] = '{pk(1, 2, 3, 4, 5, 6, 7, 8), 1'b1, pk(8, 7, 6, 5, 4, 3, 2, 1)};
      tbl[4] = '{pk(32'h80000000, 32'h7FFFFFFF, 1, 0, 32'hFFFFFFFE, 3, 3, 32'h80000001), 1'b0,
                 pk(0, 1, 3, 3, 32'h7FFFFFFF, 32'h80000000, 32'h80000001, 32'hFFFFFFFE)};

      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; sort_desc = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
      in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      chk("reset_out_last", out_last, 0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++)
         run_blk(tbl[i].din, tbl[i].desc, tbl[i].dexp, 1'b0, 1'b0, 0);

      // backpressure with a long stall mid-drain
      run_blk(tbl[0].din, 1'b0, tbl[0].dexp, 1'b0, 1'b0, 2);
      // gaps on input; sort_desc flips after beat 0 and must be ignored
      run_blk(tbl[1].din, 1'b1, tbl[1].dexp, 1'b1, 1'b1, 1);
      run_blk(tbl[0].din, 1'b0, tbl[0].dexp, 1'b1, 1'b1, 1);

      // reset at SORT cycle 10
      load_blk(tbl[0].din, 1'b0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      chk("mid_sort_valid", out_valid, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset("rst_sort");

      // reset while word 3 is on the output
      load_blk(tbl[4].din, 1'b0, 1'b0, 1'b0);
      wait_out(lat);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("drain_w3", out_data, tbl[4].dexp[3]);
      rst = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk_reset("rst_drain");
      run_blk(tbl[3].din, tbl[3].desc, tbl[3].dexp, 1'b0, 1'b0, 0);

      for (int b = 0; b < 1000; b++) begin
         for (int i = 0; i < D; i++)
            d[i] = (b % 2 == 1) ? W'($urandom_range(0, 7)) : W'($urandom);
         desc = 1'($urandom);
         run_blk(d, desc, model(d, desc), (b % 10) == 0, (b % 10) == 0, 1);
      end

      run_d2();
      run_d16();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/bitonic_sort_ctrl.md
Name: bitonic_sort_ctrl

Overview:
- Sequential bitonic sorter: captures a block of DEPTH words, sorts it in place with one shared compare-swap unit (min/max pair, dir input), then streams the sorted block out.
- Sits between an upstream producer and a downstream consumer, both using valid/ready streams.
- Trades throughput for area: one compare-swap per cycle instead of a full DEPTH-wide network.

Parameters:
- WIDTH, 32, data word width in bits; unsigned compare.
- DEPTH, 8, words per block; power of two, >= 2.
- L (localparam), log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  WIDTH  upstream word.
- sort_desc  in  1  order select; sampled on the first accepted beat of a block (1 = descending).
- out_valid  out  1  sorted word valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  sorted word.
- out_last  out  1  high with the final (DEPTH-1) output word.
- busy  out  1  high in SORT or DRAIN.

Behaviour:
- Storage: mem[0..DEPTH-1] of WIDTH bits. Index counter idx spans 0..DEPTH-1.
- States: LOAD, SORT, DRAIN. Reset enters LOAD with idx=0, stage/pair counters=0, desc_q=0, out_valid=0, out_last=0, busy=0, in_ready=1. mem contents are not reset.
- Reset has priority in any state, including mid-SORT or mid-DRAIN. A partial block is discarded.
- LOAD:
  - A beat is accepted when in_valid && in_ready: mem[idx] <= in_data, idx++.
  - The first beat (idx==0) also latches desc_q <= sort_desc.
  - On the beat with idx==DEPTH-1: go to SORT, idx <= 0, k <= 2, j <= 1, p <= 0.
- SORT, one compare-swap per cycle:
  - Loop order: k = 2,4,..,DEPTH (outer); j = k/2 down to 1; p = 0..DEPTH/2-1 (inner).
  - Indices: a = p with a 0 inserted at bit position log2(j); b = a | j.
  - Direction: up = ((a & k)==0) XOR desc_q, with k treated as DEPTH for the bit test when k==DEPTH.
  - up=1 writes mem[a] <= min and mem[b] <= max. up=0 writes the reverse.
  - Equal operands are not swapped.
  - Read, compare and write-back complete in the same cycle.
  - When p==DEPTH/2-1: p <= 0. If j==1, then k <<= 1 and j <= k (new k/2); otherwise j >>= 1.
  - After the last pair (k==DEPTH, j==1, p==DEPTH/2-1): go to DRAIN, idx <= 0.
  - SORT lasts exactly L(L+1)/2 * DEPTH/2 cycles (24 for DEPTH=8). in_ready=0 and out_valid=0 throughout.
- DRAIN:
  - out_valid=1, out_data=mem[idx], out_last=(idx==DEPTH-1).
  - Data holds stable while out_valid && !out_ready.
  - On handshake: idx++. On the handshake with out_last: go to LOAD, idx <= 0, out_valid <= 0.
  - in_ready=0 in DRAIN. No overlap of load and drain.
- Latency: last input beat at cycle T gives first out_valid at T+1+24 (DEPTH=8), with zero backpressure.
- Throughput: one block per DEPTH + 24 + DEPTH cycles minimum.
- Comparison is unsigned on the full WIDTH. Counters are sized for DEPTH with no wrap beyond DEPTH-1.

Test Plan:
- Ascending sort: rst 2 cycles, sort_desc=0, load 5,3,7,1,8,2,6,4 with in_valid held -> in_ready drops after 8th beat; out_valid rises exactly 25 cycles after the last beat; output is 1..8; out_last only on 8.
- Descending sort with duplicates and extremes: sort_desc=1, load 0,FFFFFFFF,9,9,0,1,FFFFFFFF,2 -> output FFFFFFFF,FFFFFFFF,9,9,2,1,0,0.
- Backpressure: out_ready toggled randomly and held low 5 cycles mid-drain -> out_data/out_last stable while stalled; no word lost or duplicated; in_ready stays 0 until the final handshake, then 1 the next cycle.
- Input gaps: in_valid deasserted between beats, with sort_desc changed after the first beat -> block still completes, and the order follows the value sampled at beat 0.
- Reset mid-operation: assert rst at SORT cycle 10, then again during DRAIN word 3 -> next cycle in_ready=1, out_valid=0, busy=0; a fresh block sorts correctly.
- Randomised regression: 1000 random blocks against a software sort model; also run DEPTH=2 and DEPTH=16 -> SORT lengths are 1 and 80 cycles respectively.
